// File: rtl/shift_xfer_ctrl_if.sv
// Host and shift-register side signals of the transfer sequencer, bundled as one port.
// master = requester/datapath side, slave = shift_xfer_ctrl.
interface shift_xfer_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] tx_data;
  logic             dir;
  logic             abort;
  logic             sl;
  logic             sr;
  logic             sin;
  logic             sout_in;
  logic [WIDTH-1:0] rx_data;
  logic             done;
  logic             busy;

  modport master (
    output start_valid, tx_data, dir, abort, sout_in,
    input  start_ready, sl, sr, sin, rx_data, done, busy
  );

  modport slave (
    input  start_valid, tx_data, dir, abort, sout_in,
    output start_ready, sl, sr, sin, rx_data, done, busy
  );
endinterface

// File: rtl/shift_xfer_ctrl.sv
// Drives WIDTH shift cycles per accepted word, captures the serial return, holds GAP_CYCLES, then pulses done (WIDTH+GAP_CYCLES+1 cycles).
// start_ready is high only in IDLE; requests outside IDLE are ignored, so the requester holds start_valid until accepted.
module shift_xfer_ctrl #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic               clk,
  input  logic               clear,
  shift_xfer_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int CW = $clog2(WIDTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  state_t           state;
  logic [CW-1:0]    count;
  logic [GW-1:0]    gap_cnt;
  logic [WIDTH-1:0] tx_sh;
  logic [WIDTH-1:0] rx_sh;
  logic [WIDTH-1:0] rx_q;
  logic             dir_q;
  logic             sl_q;
  logic             sr_q;
  logic             sin_q;
  logic             done_q;
  logic             busy_q;
  logic             ready_q;

  assign bus.start_ready = ready_q;
  assign bus.sl          = sl_q;
  assign bus.sr          = sr_q;
  assign bus.sin         = sin_q;
  assign bus.rx_data     = rx_q;
  assign bus.done        = done_q;
  assign bus.busy        = busy_q;

  // Outputs are registered alongside the state, so each branch loads the values for the state it enters.
  always_ff @(posedge clk) begin
    if (clear) begin
      state   <= IDLE;
      count   <= '0;
      gap_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rx_q    <= '0;
      dir_q   <= 1'b0;
      sl_q    <= 1'b0;
      sr_q    <= 1'b0;
      sin_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_valid && ready_q) begin
            tx_sh   <= bus.tx_data;
            dir_q   <= bus.dir;
            count   <= '0;
            sl_q    <= ~bus.dir;
            sr_q    <= bus.dir;
            sin_q   <= bus.dir ? bus.tx_data[0] : bus.tx_data[WIDTH-1];
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            state   <= SHIFT;
          end
        end

        SHIFT: begin
          if (bus.abort) begin
            sl_q    <= 1'b0;
            sr_q    <= 1'b0;
            sin_q   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state   <= IDLE;
          end else begin
            tx_sh <= dir_q ? {1'b0, tx_sh[WIDTH-1:1]} : {tx_sh[WIDTH-2:0], 1'b0};
            rx_sh <= dir_q ? {bus.sout_in, rx_sh[WIDTH-1:1]} : {rx_sh[WIDTH-2:0], bus.sout_in};
            count <= count + 1'b1;
            if (count == CNT_LAST) begin
              sl_q    <= 1'b0;
              sr_q    <= 1'b0;
              sin_q   <= 1'b0;
              gap_cnt <= '0;
              if (GAP_CYCLES == 0) begin
                done_q <= 1'b1;
                state  <= DONE;
              end else begin
                state  <= GAP;
              end
            end else begin
              // Next bit to present is the one that moves into the output position this edge.
              sin_q <= dir_q ? tx_sh[1] : tx_sh[WIDTH-2];
            end
          end
        end

        GAP: begin
          if (bus.abort) begin
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state   <= IDLE;
          end else if (gap_cnt == GAP_LAST) begin
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        DONE: begin
          rx_q    <= rx_sh;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_xfer_ctrl.sv
// Directed bench: default 8-bit/2-gap instance plus a 4-bit/no-gap instance, with a
// scoreboard of expected sin bits and rx words pushed at request time.
module tb_shift_xfer_ctrl;

  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  shift_xfer_ctrl_if #(.WIDTH(8)) b8 ();
  shift_xfer_ctrl_if #(.WIDTH(4)) b4 ();

  shift_xfer_ctrl #(.WIDTH(8), .GAP_CYCLES(2)) u_dut8 (
    .clk   (clk),
    .clear (clear),
    .bus   (b8.slave)
  );

  shift_xfer_ctrl #(.WIDTH(4), .GAP_CYCLES(0)) u_dut4 (
    .clk   (clk),
    .clear (clear),
    .bus   (b4.slave)
  );

  int         tests = 0;
  int         fails = 0;
  logic       sin_exp_q[$];
  logic [7:0] rx_exp_q[$];
  logic [7:0] cur_stream;
  logic       cur_dir;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue the model's sin sequence and received word, then handshake.
  task automatic start8(input logic [7:0] tx, input logic d, input logic [7:0] stream, input logic keep);
    logic [7:0] rx;
    int n;
    rx = '0;
    n  = 0;
    for (int k = 0; k < 8; k++) begin
      sin_exp_q.push_back(d ? tx[k] : tx[7-k]);
      rx = d ? {stream[k], rx[7:1]} : {rx[6:0], stream[k]};
    end
    rx_exp_q.push_back(rx);
    cur_stream = stream;
    cur_dir    = d;
    b8.start_valid = 1'b1;
    b8.tx_data     = tx;
    b8.dir         = d;
    while (b8.start_ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("accept_wait_in_budget", logic'(n < 40), 1);
    step();
    if (!keep) b8.start_valid = 1'b0;
    chk("busy_after_accept", b8.busy, 1);
    chk("ready_after_accept", b8.start_ready, 0);
  endtask

  task automatic shift8(input int abort_at, input logic [7:0] rx_prev);
    for (int k = 1; k <= 8; k++) begin
      chk("shift_sin", b8.sin, sin_exp_q.pop_front());
      chk("shift_sl", b8.sl, logic'(!cur_dir));
      chk("shift_sr", b8.sr, cur_dir);
      chk("shift_done_low", b8.done, 0);
      b8.sout_in = cur_stream[k-1];
      if (k == abort_at) b8.abort = 1'b1;
      step();
      b8.abort = 1'b0;
      if (k == abort_at) begin
        chk("abort_sl", b8.sl, 0);
        chk("abort_sr", b8.sr, 0);
        chk("abort_busy", b8.busy, 0);
        chk("abort_ready", b8.start_ready, 1);
        chk("abort_done", b8.done, 0);
        chk("abort_rx_kept", b8.rx_data, rx_prev);
        sin_exp_q.delete();
        void'(rx_exp_q.pop_front());
        return;
      end
    end
  endtask

  task automatic finish8();
    for (int g = 1; g <= 2; g++) begin
      chk("gap_sl", b8.sl, 0);
      chk("gap_sr", b8.sr, 0);
      chk("gap_sin", b8.sin, 0);
      chk("gap_done", b8.done, 0);
      chk("gap_busy", b8.busy, 1);
      step();
    end
    chk("done_pulse", b8.done, 1);
    chk("done_busy", b8.busy, 1);
    chk("done_ready", b8.start_ready, 0);
    step();
    chk("post_done_low", b8.done, 0);
    chk("post_done_ready", b8.start_ready, 1);
    chk("post_done_busy", b8.busy, 0);
    chk("rx_data", b8.rx_data, rx_exp_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] e4;
    logic [3:0] s4;
    b8.start_valid = 1'b0; b8.tx_data = '0; b8.dir = 1'b0; b8.abort = 1'b0; b8.sout_in = 1'b0;
    b4.start_valid = 1'b0; b4.tx_data = '0; b4.dir = 1'b0; b4.abort = 1'b0; b4.sout_in = 1'b0;
    clear = 1'b1;
    step();
    step();
    chk("rst_ready", b8.start_ready, 1);
    chk("rst_busy", b8.busy, 0);
    chk("rst_done", b8.done, 0);
    chk("rst_sl", b8.sl, 0);
    chk("rst_sr", b8.sr, 0);
    chk("rst_sin", b8.sin, 0);
    chk("rst_rx", b8.rx_data, 0);
    chk("rst4_ready", b4.start_ready, 1);
    clear = 1'b0;
    step();

    // Left shift, MSB first
    start8(8'hA5, 1'b0, 8'h3C, 1'b0);
    shift8(0, 8'h00);
    finish8();
    chk("rx_left_3C", b8.rx_data, 8'h3C);

    // Right shift, LSB first
    start8(8'h0F, 1'b1, 8'h81, 1'b0);
    shift8(0, 8'h3C);
    finish8();
    chk("rx_right_81", b8.rx_data, 8'h81);

    // Abort in the 4th shift cycle
    start8(8'hC3, 1'b0, 8'hFF, 1'b0);
    shift8(4, 8'h81);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_no_done", b8.done, 0);
      chk("abort_rx_hold", b8.rx_data, 8'h81);
    end

    // Request held while busy with a different word and direction
    start8(8'h3C, 1'b0, 8'h5A, 1'b1);
    b8.tx_data = 8'hFF;
    b8.dir     = 1'b1;
    shift8(0, 8'h81);
    finish8();
    start8(8'hFF, 1'b1, 8'h33, 1'b0);
    shift8(0, 8'h00);
    finish8();

    // Clear during GAP
    start8(8'h12, 1'b0, 8'hF0, 1'b0);
    shift8(0, 8'h00);
    chk("pre_clear_gap_sl", b8.sl, 0);
    chk("pre_clear_busy", b8.busy, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    void'(rx_exp_q.pop_front());
    chk("clr_ready", b8.start_ready, 1);
    chk("clr_busy", b8.busy, 0);
    chk("clr_done", b8.done, 0);
    chk("clr_sl", b8.sl, 0);
    chk("clr_sr", b8.sr, 0);
    chk("clr_sin", b8.sin, 0);
    chk("clr_rx", b8.rx_data, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("clr_no_done", b8.done, 0);
    end

    // 4-bit instance without a gap
    e4 = 4'b1001;
    s4 = 4'b1011;
    b4.start_valid = 1'b1;
    b4.tx_data     = 4'h9;
    b4.dir         = 1'b0;
    chk("w4_ready", b4.start_ready, 1);
    step();
    b4.start_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("w4_sin", b4.sin, e4[3-k]);
      chk("w4_sl", b4.sl, 1);
      chk("w4_sr", b4.sr, 0);
      chk("w4_done_low", b4.done, 0);
      b4.sout_in = s4[k];
      step();
    end
    chk("w4_done", b4.done, 1);
    chk("w4_done_sl", b4.sl, 0);
    chk("w4_done_sr", b4.sr, 0);
    chk("w4_done_busy", b4.busy, 1);
    step();
    chk("w4_post_done", b4.done, 0);
    chk("w4_post_ready", b4.start_ready, 1);
    chk("w4_rx", b4.rx_data, 4'hD);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_xfer_ctrl.md
Name: shift_xfer_ctrl

Overview:
- Sequencer for the 8-bit SISO left/right shift register.
- Accepts a parallel word over a valid/ready handshake and drives the register's Sin/sl/sr controls for exactly WIDTH shift cycles, in a per-transfer direction.
- Captures the returning serial stream into a parallel receive word, then holds the register for a configurable settle gap and signals completion.
- Sits between the host/control logic and the shift register datapath.

Parameters:
- WIDTH, 8, bits per transfer; must be ≥2.
- GAP_CYCLES, 2, hold cycles after the last shift (sl=sr=0) before done; 0 is legal and skips GAP.

Ports:
- clk  input  1  rising-edge clock
- clear  input  1  synchronous active-high reset
- start_valid  input  1  transfer request
- start_ready  output  1  controller can accept a request
- tx_data  input  WIDTH  word to shift out, captured on handshake
- dir  input  1  captured on handshake; 0 = left shift/MSB first, 1 = right shift/LSB first
- abort  input  1  cancel the transfer in progress
- sl  output  1  shift-left enable to the register
- sr  output  1  shift-right enable to the register
- sin  output  1  serial data to the register
- sout_in  input  1  serial return line, sampled during SHIFT
- rx_data  output  WIDTH  last completed received word
- done  output  1  one-cycle pulse, transfer complete
- busy  output  1  high in any state except IDLE

Behaviour:
- Reset: clear sampled high at a rising edge forces IDLE with count=0, tx_sh=0, rx_sh=0, rx_data=0, dir_q=0. Outputs become start_ready=1, busy=0, done=0, sl=0, sr=0, sin=0.
- Reset priority: clear overrides all inputs, including mid-transfer. No done is produced for an interrupted transfer.
- States: IDLE, SHIFT, GAP, DONE. The state register is binary-encoded.
- Output timing: all outputs decode from registered state only. No combinational path from any input to any output.
- IDLE:
  - start_ready=1.
  - On start_valid&&start_ready: tx_sh<=tx_data, dir_q<=dir, count<=0, go to SHIFT.
  - abort is ignored in IDLE.
- SHIFT (exactly WIDTH cycles, count 0..WIDTH-1):
  - Direction controls: sl=~dir_q, sr=dir_q. They are never both high and never both high-and-low-glitching within a transfer.
  - sin = tx_sh[WIDTH-1] when dir_q=0, else tx_sh[0].
  - Each edge shifts tx_sh one place in the transfer direction and shifts sout_in into rx_sh. For dir_q=0, rx_sh<={rx_sh[WIDTH-2:0],sout_in}. For dir_q=1, rx_sh<={sout_in,rx_sh[WIDTH-1:1]}.
  - When count==WIDTH-1: go to GAP, or to DONE if GAP_CYCLES==0.
- GAP (GAP_CYCLES cycles):
  - sl=sr=0, sin=0. The register holds.
  - A gap counter counts to GAP_CYCLES-1, then the FSM goes to DONE.
- DONE (1 cycle):
  - done=1 and busy=1.
  - rx_data<=rx_sh on the exit edge, so rx_data is valid from the cycle after done and held until the next DONE.
  - Then go to IDLE.
- abort in SHIFT or GAP: next state is IDLE, sl=sr=0 from the next cycle, no done, rx_data unchanged. abort in DONE is ignored and done still completes.
- start_valid outside IDLE is ignored; there is no queuing. The requester must hold start_valid until start_ready.
- Latency (handshake edge = edge 0):
  - SHIFT occupies cycles 1..WIDTH.
  - GAP occupies cycles WIDTH+1..WIDTH+GAP_CYCLES.
  - done is in cycle WIDTH+GAP_CYCLES+1.
  - start_ready rises the following cycle.
  - Defaults: done in cycle 11, next accept no earlier than edge 12.
- Throughput: at least one IDLE cycle between transfers.

Test Plan:
- Reset, then dir=0, tx_data=0xA5, sout_in stream 0,0,1,1,1,1,0,0 during SHIFT -> sin=1,0,1,0,0,1,0,1 with sl=1, sr=0 for 8 cycles; 2 cycles of sl=sr=0; done pulse in cycle 11; rx_data=0x3C; start_ready=1 in cycle 12.
- dir=1, tx_data=0x0F, sout_in stream 1,0,0,0,0,0,0,1 -> sin=1,1,1,1,0,0,0,0 with sr=1, sl=0; rx_data=0x81.
- abort asserted in the 4th SHIFT cycle -> IDLE next cycle, sl=sr=0, busy=0, start_ready=1, no done, rx_data keeps the previous 0x81.
- start_valid held high with a new tx_data=0xFF while busy -> ignored; the current transfer's sin sequence is unchanged; the new word is accepted only in the IDLE cycle after done.
- clear pulsed in GAP -> next cycle all outputs at reset values, rx_data=0, no done.
- Build with GAP_CYCLES=0, WIDTH=4, tx_data=0x9, dir=0 -> sin=1,0,0,1; done in cycle 5; sl never high in cycle 5.
